// File: rtl/portv_pkg.sv
// Shared constants, state type and pointer-wrap helper for the PortV read requester.
package portv_pkg;

    localparam int PTR_W           = 19;
    localparam int ADDR_W          = 25;
    localparam int FRAME_WORDS     = 307200;
    localparam int MAX_OUTSTANDING = 64;
    localparam int FILL_LIMIT      = 448;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(FRAME_WORDS - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

endpackage

// File: rtl/portv_frame_ptr.sv
// Frame pixel pointer: wraps at FRAME_WORDS-1, with increment and load.
import portv_pkg::*;

module portv_frame_ptr (
    input  logic             clk,
    input  logic             portV_arst,
    input  logic             inc,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = wrapInc(ptr_q);
        end
    end

    always_ff @(posedge clk or posedge portV_arst) begin
        if (portV_arst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/portv_read_requester.sv
// PortV scan-out read requester: raster-order SDRAM reads throttled by FIFO fill + reads in flight.
// Optional statistics outputs (staleCount, reqCount) are built when PORTV_REQ_STATS_EN is defined.
//
// state  | meaning
// S_IDLE | no request pending; throttle inputs evaluated every cycle
// S_REQ  | rreq asserted, rreqAddr held until rready
import portv_pkg::*;

module portv_read_requester (
    input  logic              clk,
    input  logic              portV_arst,
    input  logic [ADDR_W-1:0] readOffset,
    input  logic [8:0]        PortVout_usedw,
    input  logic              PortVout_wrreq,
    input  logic              PortVout_nullData,
    input  logic              readValid,
    output logic              rreq,
    input  logic              rready,
    output logic [ADDR_W-1:0] rreqAddr
`ifdef PORTV_REQ_STATS_EN
    ,
    output logic [15:0]       staleCount,
    output logic [31:0]       reqCount
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [PTR_W-1:0]  req_ptr;
    logic [PTR_W-1:0]  trk_ptr;
    logic [PTR_W-1:0]  trk_ptr_inc;
    logic [PTR_W-1:0]  issue_ptr;
    logic [6:0]        outstanding_q;
    logic [6:0]        outstanding_d;
    logic [ADDR_W-1:0] addr_q;
    logic [9:0]        fill_sum;
    logic              can_issue;
    logic              load_addr;
    logic              accept;
    logic              null_ins;
    logic              ptrs_equal;
    logic              resync;
    logic              rv_eff;

    assign fill_sum    = {1'b0, PortVout_usedw} + {3'b000, outstanding_q};
    assign can_issue   = (fill_sum < 10'(FILL_LIMIT)) && (outstanding_q < 7'(MAX_OUTSTANDING));
    assign accept      = (state_q == S_REQ) && rready;
    assign null_ins    = PortVout_wrreq && PortVout_nullData;
    assign ptrs_equal  = (req_ptr == trk_ptr);
    // A pending request keeps its pointer; the return path discards that word as stale.
    assign resync      = null_ins && ptrs_equal && (state_q == S_IDLE);
    assign rv_eff      = readValid && (outstanding_q != 7'd0);
    assign trk_ptr_inc = wrapInc(trk_ptr);
    // On a same-cycle resync the request already targets the pixel after the skipped one.
    assign issue_ptr   = resync ? trk_ptr_inc : req_ptr;

    portv_frame_ptr u_req_ptr (
        .clk        (clk),
        .portV_arst (portV_arst),
        .inc        (accept),
        .load       (resync),
        .load_val   (trk_ptr_inc),
        .ptr        (req_ptr)
    );

    portv_frame_ptr u_trk_ptr (
        .clk        (clk),
        .portV_arst (portV_arst),
        .inc        (PortVout_wrreq),
        .load       (1'b0),
        .load_val   ('0),
        .ptr        (trk_ptr)
    );

    always_comb begin
        state_d   = state_q;
        load_addr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_issue) begin
                    state_d   = S_REQ;
                    load_addr = 1'b1;
                end
            end
            S_REQ: begin
                if (rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, rv_eff})
            2'b10:   outstanding_d = outstanding_q + 7'd1;
            2'b01:   outstanding_d = outstanding_q - 7'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge portV_arst) begin
        if (portV_arst) begin
            state_q       <= S_IDLE;
            outstanding_q <= '0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            if (load_addr) begin
                addr_q <= readOffset + {{(ADDR_W-PTR_W){1'b0}}, issue_ptr};
            end
        end
    end

    assign rreq     = (state_q == S_REQ);
    assign rreqAddr = addr_q;

`ifdef PORTV_REQ_STATS_EN
    logic [15:0] stale_q;
    logic [31:0] req_cnt_q;

    always_ff @(posedge clk or posedge portV_arst) begin
        if (portV_arst) begin
            stale_q   <= '0;
            req_cnt_q <= '0;
        end else begin
            if (null_ins && !ptrs_equal && (stale_q != 16'hFFFF)) begin
                stale_q <= stale_q + 16'd1;
            end
            if (accept) begin
                req_cnt_q <= req_cnt_q + 32'd1;
            end
        end
    end

    assign staleCount = stale_q;
    assign reqCount   = req_cnt_q;
`endif

endmodule

// File: tb/tb_portv_read_requester.sv
// Self-checking bench for portv_read_requester: address scoreboard, throttle vector table, corner sequences.
module tb_portv_read_requester;

    logic        clk;
    logic        portV_arst;
    logic [24:0] readOffset;
    logic [8:0]  PortVout_usedw;
    logic        PortVout_wrreq;
    logic        PortVout_nullData;
    logic        readValid;
    logic        rreq;
    logic        rready;
    logic [24:0] rreqAddr;
`ifdef PORTV_REQ_STATS_EN
    logic [15:0] staleCount;
    logic [31:0] reqCount;
`endif

    portv_read_requester dut (
        .clk               (clk),
        .portV_arst        (portV_arst),
        .readOffset        (readOffset),
        .PortVout_usedw    (PortVout_usedw),
        .PortVout_wrreq    (PortVout_wrreq),
        .PortVout_nullData (PortVout_nullData),
        .readValid         (readValid),
        .rreq              (rreq),
        .rready            (rready),
        .rreqAddr          (rreqAddr)
`ifdef PORTV_REQ_STATS_EN
        ,
        .staleCount        (staleCount),
        .reqCount          (reqCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] addr;
        int          tick;
    } exp_req_t;

    typedef struct {
        logic [8:0] usedw;
        int         nout;
        logic       exp_rreq;
    } thr_vec_t;

    exp_req_t sb[$];
    thr_vec_t tv[8];
    int       total;
    int       passed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [8:0] usedw, input logic rdy);
        portV_arst        = 1'b1;
        PortVout_usedw    = usedw;
        rready            = rdy;
        PortVout_wrreq    = 1'b0;
        PortVout_nullData = 1'b0;
        readValid         = 1'b0;
        tick();
        tick();
        portV_arst = 1'b0;
    endtask

    // Pops one expected request per observed handshake; tick index is relative to the call.
    task automatic collect(input int n);
        exp_req_t e;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (rreq && rready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_req: got addr 0x%0h at tick %0d, required no request", rreqAddr, k);
                end else begin
                    e = sb.pop_front();
                    check("req_addr", 32'(rreqAddr), 32'(e.addr));
                    check("req_tick", k, e.tick);
                end
            end
        end
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        tv[0] = '{9'd440, 8,  1'b0};
        tv[1] = '{9'd439, 8,  1'b1};
        tv[2] = '{9'd447, 0,  1'b1};
        tv[3] = '{9'd448, 0,  1'b0};
        tv[4] = '{9'd0,   63, 1'b1};
        tv[5] = '{9'd0,   64, 1'b0};
        tv[6] = '{9'd380, 60, 1'b1};
        tv[7] = '{9'd390, 60, 1'b0};

        readOffset = 25'd0;
        portV_arst = 1'b1;
        PortVout_usedw = 9'd0; rready = 1'b1;
        PortVout_wrreq = 1'b0; PortVout_nullData = 1'b0; readValid = 1'b0;
        tick();
        check("rst_rreq", 32'(rreq), 0);
        check("rst_addr", 32'(rreqAddr), 0);
        check("rst_outstanding", 32'(dut.outstanding_q), 0);
        check("rst_reqptr", 32'(dut.req_ptr), 0);

        // Basic cadence and 25-bit truncation of the address sum
        readOffset = 25'h1FFFFFE;
        do_reset(9'd0, 1'b1);
        sb.push_back('{25'h1FFFFFE, 1});
        sb.push_back('{25'h1FFFFFF, 3});
        sb.push_back('{25'h0000000, 5});
        sb.push_back('{25'h0000001, 7});
        collect(8);
        PortVout_usedw = 9'd448;
        check("basic_outstanding", 32'(dut.outstanding_q), 4);
        tick();
        check("basic_throttled", 32'(rreq), 0);

        // Request held stable while rready is low
        readOffset = 25'd500;
        do_reset(9'd0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            readOffset = 25'(600 + i * 7);
            tick();
            check("hold_rreq", 32'(rreq), 1);
            check("hold_addr", 32'(rreqAddr), 500);
        end
        rready = 1'b1;
        PortVout_usedw = 9'd448;
        tick();
        rready = 1'b0;
        check("hold_outstanding", 32'(dut.outstanding_q), 1);
        check("hold_rreq_drop", 32'(rreq), 0);

        // Throttle vectors: build nout reads in flight, then present usedw
        readOffset = 25'd0;
        for (int v = 0; v < 8; v++) begin
            do_reset(9'd0, 1'b1);
            repeat (2 * tv[v].nout) tick();
            PortVout_usedw = tv[v].usedw;
            check("thr_outstanding", 32'(dut.outstanding_q), tv[v].nout);
            tick();
            check("thr_rreq", 32'(rreq), 32'(tv[v].exp_rreq));
        end

        // 440 used + 8 in flight blocks; one return reopens issue
        do_reset(9'd0, 1'b1);
        repeat (16) tick();
        PortVout_usedw = 9'd440;
        tick();
        check("rv_blocked", 32'(rreq), 0);
        readValid = 1'b1;
        tick();
        readValid = 1'b0;
        check("rv_outstanding", 32'(dut.outstanding_q), 7);
        tick();
        check("rv_reissue", 32'(rreq), 1);

        // Frame wrap from a preloaded last pixel
        do_reset(9'd448, 1'b1);
        force dut.u_req_ptr.ptr_q = 19'd307199;
        force dut.u_trk_ptr.ptr_q = 19'd307199;
        tick();
        release dut.u_req_ptr.ptr_q;
        release dut.u_trk_ptr.ptr_q;
        tick();
        check("wrap_preload", 32'(dut.req_ptr), 307199);
        readOffset = 25'd2000;
        PortVout_usedw = 9'd0;
        sb.push_back('{25'd309199, 1});
        sb.push_back('{25'd2000, 3});
        collect(4);
        PortVout_usedw = 9'd448;
        check("wrap_reqptr", 32'(dut.req_ptr), 1);
        PortVout_wrreq = 1'b1;
        tick();
        PortVout_wrreq = 1'b0;
        check("wrap_trkptr", 32'(dut.trk_ptr), 0);
        check("realwr_reqptr", 32'(dut.req_ptr), 1);

        // Null inserts with lead 0, then with lead 2
        readOffset = 25'd3000;
        do_reset(9'd448, 1'b1);
        PortVout_wrreq = 1'b1; PortVout_nullData = 1'b1;
        repeat (3) tick();
        PortVout_wrreq = 1'b0; PortVout_nullData = 1'b0;
        check("null_reqptr", 32'(dut.req_ptr), 3);
        check("null_trkptr", 32'(dut.trk_ptr), 3);
        PortVout_usedw = 9'd0;
        sb.push_back('{25'd3003, 1});
        sb.push_back('{25'd3004, 3});
        collect(4);
        PortVout_usedw = 9'd448;
        PortVout_wrreq = 1'b1; PortVout_nullData = 1'b1;
        tick();
        PortVout_wrreq = 1'b0; PortVout_nullData = 1'b0;
        check("lead_reqptr", 32'(dut.req_ptr), 5);
        check("lead_trkptr", 32'(dut.trk_ptr), 4);
`ifdef PORTV_REQ_STATS_EN
        check("stale_count", 32'(staleCount), 1);
        check("req_count", reqCount, 2);
`endif

        // Zero saturation, and accept with readValid in the same cycle
        do_reset(9'd448, 1'b0);
        readValid = 1'b1;
        tick();
        readValid = 1'b0;
        check("sat_zero", 32'(dut.outstanding_q), 0);
        PortVout_usedw = 9'd0; rready = 1'b1;
        tick();
        PortVout_usedw = 9'd448;
        tick();
        rready = 1'b0;
        check("one_out", 32'(dut.outstanding_q), 1);
        PortVout_usedw = 9'd0;
        tick();
        PortVout_usedw = 9'd448;
        check("pending_rreq", 32'(rreq), 1);
        rready = 1'b1; readValid = 1'b1;
        tick();
        rready = 1'b0; readValid = 1'b0;
        check("acc_rv_outstanding", 32'(dut.outstanding_q), 1);

        // Asynchronous reset drops a pending request immediately
        PortVout_usedw = 9'd0;
        tick();
        check("pre_arst_rreq", 32'(rreq), 1);
        portV_arst = 1'b1;
        #1;
        check("arst_rreq", 32'(rreq), 0);
        check("arst_addr", 32'(rreqAddr), 0);
        check("arst_outstanding", 32'(dut.outstanding_q), 0);
        @(negedge clk);
        portV_arst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/portv_read_requester.md
# portv_read_requester

Issues SDRAM read requests for the VGA scan-out port (PortV), walking the 640×480 frame in raster order from a programmable base offset. It is the request-side counterpart of the PortV return path: it throttles on output-FIFO fill level plus reads in flight. It also mirrors the return path's frame pointer, so it never requests addresses that the return path has already skipped with null data. It sits between the PortV output FIFO and the SDRAM controller read command port.

## Interface
- FRAME_WORDS, 307200: pixels per frame; the address pointer wraps at FRAME_WORDS-1.
- MAX_OUTSTANDING, 64: maximum accepted-but-unreturned reads.
- FILL_LIMIT, 448: issue only while usedw + outstanding < FILL_LIMIT.
- clk  in  1  system clock.
- portV_arst  in  1  asynchronous, active-high reset.
- readOffset  in  25  frame base address in SDRAM; sampled when each request is formed.
- PortVout_usedw  in  9  output FIFO fill level.
- PortVout_wrreq  in  1  return path writes the FIFO this cycle (real or null).
- PortVout_nullData  in  1  qualifies PortVout_wrreq as a null write.
- readValid  in  1  one read word returned by SDRAM; may be stale.
- rreq  out  1  read request valid.
- rready  in  1  controller accepts the request when rreq & rready.
- rreqAddr  out  25  requested address = readOffset + reqPtr.

## Operation
- Internal registers:
  - reqPtr[18:0]: next pixel to request.
  - trkPtr[18:0]: mirror of the return-path pointer; advances on every PortVout_wrreq.
  - outstanding[6:0].
- FSM has two states, S_IDLE and S_REQ.
  - S_IDLE → S_REQ when usedw + outstanding < FILL_LIMIT and outstanding < MAX_OUTSTANDING. On that edge: rreq=1 and rreqAddr is registered.
  - S_REQ holds rreq and rreqAddr stable until rready.
  - On accept: reqPtr increments with wrap, outstanding increments, and the FSM returns to S_IDLE. There are no back-to-back requests; at most one request every 2 cycles.
- Outstanding count: +1 on accept, -1 on readValid, unchanged when both occur in the same cycle. It saturates at 0: readValid with outstanding==0 is ignored. Accept never occurs at MAX_OUTSTANDING.
- Resync on null insert (PortVout_wrreq & PortVout_nullData):
  - Compute lead = (reqPtr - trkPtr) mod FRAME_WORDS. If lead==0, reqPtr advances with trkPtr.
  - If a request is pending in S_REQ with reqPtr==trkPtr, the address is not changed mid-handshake. The returned word is discarded as stale by the return path, and reqPtr advances at accept as usual.
- Wrap: 307199+1 → 0 for both pointers. Widths are 19 bits internally; the address is a 25-bit zero-extended sum, and overflow beyond 25 bits truncates.

## Timing
- Reset values: rreq=0, rreqAddr=0, state=S_IDLE, reqPtr=trkPtr=0, outstanding=0.
- Reset mid-handshake drops rreq immediately (asynchronous). Reads returned after reset are absorbed by the zero-saturation rule.
- Latency: condition true in S_IDLE at edge N → rreq high after edge N.
- Throttle inputs are sampled only in S_IDLE. usedw is a registered FIFO output, so one cycle of staleness is tolerated by FILL_LIMIT headroom (512-448).
- Simultaneous events in one cycle (accept + readValid + null insert) are all applied in that cycle.

## Configuration
- PORTV_REQ_STATS_EN defined:
  - Adds output staleCount[15:0], which counts null inserts while lead>0 and saturates at 0xFFFF.
  - Adds output reqCount[31:0], which counts accepts and wraps.
  - Both outputs reset to 0.
- Undefined: the stats ports and logic are absent; all other behaviour is identical.

## Structure
- Package portv_pkg holds FRAME_WORDS, the pointer width (19), the address width (25), the state enum type, and the function wrapInc(ptr) used by both pointers.
- Sub-module portv_frame_ptr: a 19-bit wrapping counter with inc and load. It is instantiated twice, for reqPtr and trkPtr.

## Test plan
- Reset, usedw=0, rready=1 → rreq at first edge after reset release, rreqAddr=readOffset; second request 2 cycles later at readOffset+1.
- rready held low for 5 cycles with readOffset changing → rreqAddr and rreq stable throughout; a single accept increments outstanding to 1.
- usedw=440 with 8 outstanding → no rreq. Return 1 readValid → rreq issued within 2 cycles.
- Preload reqPtr=trkPtr=307199 with accept → reqPtr=0, next rreqAddr=readOffset+0.
- lead==0, pulse null insert 3 times → reqPtr and trkPtr both +3; next rreqAddr=readOffset+3. With lead=2, one null insert → reqPtr unchanged and, with stats enabled, staleCount=1.
- readValid with outstanding==0 → outstanding stays 0. Accept and readValid in the same cycle → outstanding unchanged.
